// File: rtl/cr_prefix_rec_di_gen.sv
// Data-input stage for the prefix recognizer neuron array: input planes, local
// registers, per-neuron gather and coefficient pipeline. Optional parity: CR_PREFIX_DI_PARITY_EN.
module cr_prefix_rec_di_gen #(
  parameter int N     = 128,
  parameter int W     = 8,
  parameter int N_IP  = 2,
  parameter int N_LR  = 2,
  parameter int IDX_W = $clog2(N),
  parameter int SEL_W = $clog2(N_IP + N_LR)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_IP*N*W-1:0]   fe_ip_data,
  input  logic [N_IP-1:0]       fe_ip_ld,
  input  logic                  ip_rst,
  input  logic [N*W-1:0]        act_result,
  input  logic [N_LR-1:0]       lr_ld,
  input  logic                  lr_clr,
  input  logic [SEL_W-1:0]      drsel,
  input  logic [N*IDX_W-1:0]    rx_in,
  input  logic [N*W-1:0]        coeff_in,
  input  logic                  in_valid,
  input  logic                  hold,
  input  logic                  step,
  input  logic                  snap,
  input  logic                  ir1_halt,
  input  logic                  ir2_halt,
  output logic [N*W-1:0]        datareg,
  output logic [N*IDX_W-1:0]    rx,
  output logic [N*W-1:0]        coeff,
  output logic [N*W-1:0]        neuron,
  output logic                  neuron_sign,
  output logic                  out_valid
`ifdef CR_PREFIX_DI_PARITY_EN
  ,
  output logic [N-1:0]          coeff_par,
  output logic [N-1:0]          neuron_par
`endif
);

  logic [N*W-1:0]     planes [N_IP];
  logic [N*W-1:0]     lregs  [N_LR];
  logic [N*IDX_W-1:0] snap_rx;
  logic [N*W-1:0]     snap_coeff;
  logic               hold_dly;
  logic               s1_sign;
  logic               s1_valid;

  logic [N*W-1:0]     sel_data;
  logic [N*IDX_W-1:0] rx_d;
  logic [N*W-1:0]     coeff_d;
  logic [N*W-1:0]     neuron_d;

  // NOTE: the register arrays are reset explicitly because reset must leave every
  // plane and local register at zero; this keeps them out of RAM inference.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < N_IP; p++) planes[p] <= '0;
      for (int r = 0; r < N_LR; r++) lregs[r] <= '0;
    end else begin
      // Load wins over clear, independently per plane / per register.
      for (int p = 0; p < N_IP; p++) begin
        if (fe_ip_ld[p])  planes[p] <= fe_ip_data[p*N*W +: N*W];
        else if (ip_rst)  planes[p] <= '0;
      end
      for (int r = 0; r < N_LR; r++) begin
        if (lr_ld[r])     lregs[r] <= act_result;
        else if (lr_clr)  lregs[r] <= '0;
      end
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred
  // for an unmatched drsel value.
  always_comb begin
    sel_data = '0;
    for (int p = 0; p < N_IP; p++)
      if (int'(drsel) == p) sel_data = planes[p];
    for (int r = 0; r < N_LR; r++)
      if (int'(drsel) == N_IP + r) sel_data = lregs[r];
  end

  // The first cycle after a hold replays the snapshot indices.
  assign rx_d    = ir1_halt ? '0 : (hold_dly ? snap_rx : rx_in);
  assign coeff_d = ir2_halt ? '0 : (step ? snap_coeff : coeff_in);

  always_comb begin
    neuron_d = '0;
    for (int k = 0; k < N; k++)
      neuron_d[k*W +: W] = datareg[int'(rx[k*IDX_W +: IDX_W])*W +: W];
  end

  // NOTE: non-blocking assignments for all state so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_rx    <= '0;
      snap_coeff <= '0;
      hold_dly   <= 1'b0;
    end else begin
      hold_dly <= hold;
      if (snap) begin
        snap_rx    <= rx_in;
        snap_coeff <= coeff_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx          <= '0;
      datareg     <= '0;
      s1_sign     <= 1'b0;
      s1_valid    <= 1'b0;
      neuron      <= '0;
      neuron_sign <= 1'b0;
      out_valid   <= 1'b0;
      coeff       <= '0;
    end else if (!hold) begin
      rx          <= rx_d;
      datareg     <= sel_data;
      s1_sign     <= (int'(drsel) >= N_IP);
      s1_valid    <= in_valid & ~ir1_halt;
      neuron      <= neuron_d;
      neuron_sign <= s1_sign;
      out_valid   <= s1_valid;
      coeff       <= coeff_d;
    end
  end

`ifdef CR_PREFIX_DI_PARITY_EN
  function automatic logic [N-1:0] lane_par(input logic [N*W-1:0] v);
    logic [N-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) r[k] = ^v[k*W +: W];
    return r;
  endfunction

  // Parity is computed from the next-state data so it lands in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coeff_par  <= '0;
      neuron_par <= '0;
    end else if (!hold) begin
      coeff_par  <= lane_par(coeff_d);
      neuron_par <= lane_par(neuron_d);
    end
  end
`endif

endmodule

// File: tb/tb_cr_prefix_rec_di_gen.sv
// Directed self-checking bench for cr_prefix_rec_di_gen; parity checks compile
// in when CR_PREFIX_DI_PARITY_EN is defined.
module tb_cr_prefix_rec_di_gen;
  localparam int N     = 128;
  localparam int W     = 8;
  localparam int N_IP  = 2;
  localparam int N_LR  = 2;
  localparam int IDX_W = 7;
  localparam int SEL_W = 2;
  localparam int NW    = N * W;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [N_IP*NW-1:0]  fe_ip_data;
  logic [N_IP-1:0]     fe_ip_ld;
  logic                ip_rst;
  logic [NW-1:0]       act_result;
  logic [N_LR-1:0]     lr_ld;
  logic                lr_clr;
  logic [SEL_W-1:0]    drsel;
  logic [N*IDX_W-1:0]  rx_in;
  logic [NW-1:0]       coeff_in;
  logic                in_valid, hold, step, snap, ir1_halt, ir2_halt;
  logic [NW-1:0]       datareg, coeff, neuron;
  logic [N*IDX_W-1:0]  rx;
  logic                neuron_sign, out_valid;
`ifdef CR_PREFIX_DI_PARITY_EN
  logic [N-1:0]        coeff_par, neuron_par;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    string         tag;
    logic [NW-1:0] exp;
  } sb_t;
  sb_t sb_q[$];

  cr_prefix_rec_di_gen #(
    .N(N), .W(W), .N_IP(N_IP), .N_LR(N_LR), .IDX_W(IDX_W), .SEL_W(SEL_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .fe_ip_data(fe_ip_data), .fe_ip_ld(fe_ip_ld),
    .ip_rst(ip_rst), .act_result(act_result), .lr_ld(lr_ld), .lr_clr(lr_clr),
    .drsel(drsel), .rx_in(rx_in), .coeff_in(coeff_in), .in_valid(in_valid),
    .hold(hold), .step(step), .snap(snap), .ir1_halt(ir1_halt), .ir2_halt(ir2_halt),
    .datareg(datareg), .rx(rx), .coeff(coeff), .neuron(neuron),
    .neuron_sign(neuron_sign), .out_valid(out_valid)
`ifdef CR_PREFIX_DI_PARITY_EN
    , .coeff_par(coeff_par), .neuron_par(neuron_par)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [NW-1:0] fill(input logic [W-1:0] b);
    logic [NW-1:0] r;
    for (int k = 0; k < N; k++) r[k*W +: W] = b;
    return r;
  endfunction

  function automatic logic [NW-1:0] ramp();
    logic [NW-1:0] r;
    for (int k = 0; k < N; k++) r[k*W +: W] = W'(k);
    return r;
  endfunction

  function automatic logic [NW-1:0] rev_vals();
    logic [NW-1:0] r;
    for (int k = 0; k < N; k++) r[k*W +: W] = W'(N - 1 - k);
    return r;
  endfunction

  function automatic logic [N*IDX_W-1:0] rx_fill(input int v);
    logic [N*IDX_W-1:0] r;
    for (int k = 0; k < N; k++) r[k*IDX_W +: IDX_W] = IDX_W'(v);
    return r;
  endfunction

  function automatic logic [N*IDX_W-1:0] rx_rev();
    logic [N*IDX_W-1:0] r;
    for (int k = 0; k < N; k++) r[k*IDX_W +: IDX_W] = IDX_W'(N - 1 - k);
    return r;
  endfunction

  task automatic check(input string tag, input logic [NW-1:0] obs, input logic [NW-1:0] exp);
    int bad;
    checks++;
    assert (obs === exp) else begin
      errors++;
      bad = -1;
      for (int i = NW - 1; i >= 0; i--) if (obs[i] !== exp[i]) bad = i;
      $error("FAIL %s: observed %h expected %h (low 64 bits, first bad bit %0d)",
             tag, obs[63:0], exp[63:0], bad);
    end
  endtask

  task automatic sb_push(input string tag, input logic [NW-1:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input logic [NW-1:0] obs);
    sb_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard: observed %h expected <empty queue>", obs[63:0]);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, obs, e.exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Reset with every input driven high.
    rst_n = 1'b0;
    fe_ip_data = '1; fe_ip_ld = '1; ip_rst = 1'b1; act_result = '1; lr_ld = '1;
    lr_clr = 1'b1; drsel = '1; rx_in = '1; coeff_in = '1; in_valid = 1'b1;
    hold = 1'b1; step = 1'b1; snap = 1'b1; ir1_halt = 1'b1; ir2_halt = 1'b1;
    #12;
    check("rst_datareg", datareg, '0);
    check("rst_rx", NW'(rx), '0);
    check("rst_coeff", coeff, '0);
    check("rst_neuron", neuron, '0);
    check("rst_sign", NW'(neuron_sign), '0);
    check("rst_valid", NW'(out_valid), '0);
`ifdef CR_PREFIX_DI_PARITY_EN
    check("rst_coeff_par", NW'(coeff_par), '0);
    check("rst_neuron_par", NW'(neuron_par), '0);
`endif
    @(negedge clk);
    fe_ip_data = '0; fe_ip_ld = '0; ip_rst = 1'b0; act_result = '0; lr_ld = '0;
    lr_clr = 1'b0; drsel = '0; rx_in = '0; coeff_in = '0; in_valid = 1'b0;
    hold = 1'b0; step = 1'b0; snap = 1'b0; ir1_halt = 1'b0; ir2_halt = 1'b0;
    rst_n = 1'b1;
    cyc();

    // Load plane0 with a ramp and plane1 with 0xAA, then gather reversed.
    fe_ip_data = {fill(8'hAA), ramp()};
    fe_ip_ld = 2'b11;
    cyc();
    fe_ip_ld = '0; drsel = 2'd0; rx_in = rx_rev(); coeff_in = fill(8'h5A); in_valid = 1'b1;
    sb_push("gather_rev", rev_vals());
    cyc();
    check("plane0_datareg", datareg, ramp());
    check("rx_latency1", NW'(rx), NW'(rx_rev()));
    check("coeff_latency1", coeff, fill(8'h5A));
    in_valid = 1'b0; drsel = 2'd1; rx_in = rx_fill(0);
    sb_push("gather_plane1", fill(8'hAA));
    cyc();
    sb_check(neuron);
    check("plane_sign", NW'(neuron_sign), '0);
    check("valid_live", NW'(out_valid), NW'(1));
    check("plane1_datareg", datareg, fill(8'hAA));
    cyc();
    sb_check(neuron);
    check("valid_drop", NW'(out_valid), '0);

    // Load beats clear on plane1 while plane0 clears.
    fe_ip_data = {fill(8'h3C), fill(8'hFF)}; fe_ip_ld = 2'b10; ip_rst = 1'b1;
    cyc();
    fe_ip_ld = '0; ip_rst = 1'b0; drsel = 2'd0;
    cyc();
    check("ip_rst_clear", datareg, '0);
    drsel = 2'd1;
    cyc();
    check("ip_ld_over_rst", datareg, fill(8'h3C));

    // Reload plane0 ramp for later gathers; local registers load 0x80.
    fe_ip_data = {fill(8'h3C), ramp()}; fe_ip_ld = 2'b01;
    act_result = fill(8'h80); lr_ld = 2'b11;
    cyc();
    fe_ip_ld = '0; lr_ld = '0; drsel = 2'(N_IP + 1); rx_in = rx_fill(0); in_valid = 1'b1;
    sb_push("lr_gather", fill(8'h80));
    cyc();
    check("lr1_datareg", datareg, fill(8'h80));
    cyc();
    sb_check(neuron);
    check("lr_sign", NW'(neuron_sign), NW'(1));
    act_result = fill(8'h44); lr_ld = 2'b10; lr_clr = 1'b1;
    cyc();
    lr_ld = '0; lr_clr = 1'b0;
    cyc();
    check("lr_ld_over_clr", datareg, fill(8'h44));
    drsel = 2'(N_IP);
    cyc();
    check("lr_clr", datareg, '0);

    // Hold freezes the pipeline; snap during hold is replayed on release.
    drsel = 2'd0; rx_in = rx_rev(); coeff_in = fill(8'h21); in_valid = 1'b1;
    sb_push("pre_hold", rev_vals());
    cyc();
    cyc();
    sb_check(neuron);
    hold = 1'b1; snap = 1'b1; rx_in = rx_fill(5); coeff_in = fill(8'h77);
    drsel = 2'd1; in_valid = 1'b0;
    for (int h = 0; h < 3; h++) begin
      cyc();
      snap = 1'b0; rx_in = rx_fill(9); coeff_in = fill(8'h99);
      check($sformatf("hold%0d_rx", h), NW'(rx), NW'(rx_rev()));
      check($sformatf("hold%0d_coeff", h), coeff, fill(8'h21));
      check($sformatf("hold%0d_neuron", h), neuron, rev_vals());
      check($sformatf("hold%0d_valid", h), NW'(out_valid), NW'(1));
    end
    hold = 1'b0;
    cyc();
    check("replay_rx", NW'(rx), NW'(rx_fill(5)));
    check("release_coeff", coeff, fill(8'h99));
    cyc();
    check("post_replay_rx", NW'(rx), NW'(rx_fill(9)));

    // Coefficient snapshot and step.
    snap = 1'b1; coeff_in = fill(8'h33);
    cyc();
    check("snap_pass", coeff, fill(8'h33));
    snap = 1'b0; coeff_in = fill(8'h11); step = 1'b1;
    cyc();
    check("step_replay", coeff, fill(8'h33));
    ir2_halt = 1'b1;
    cyc();
    check("ir2_halt", coeff, '0);
    ir2_halt = 1'b0; snap = 1'b1; coeff_in = fill(8'h55);
    cyc();
    check("snap_step_old", coeff, fill(8'h33));
    snap = 1'b0; coeff_in = fill(8'h11);
    cyc();
    check("snap_step_new", coeff, fill(8'h55));
    step = 1'b0;

    // ir1_halt zeroes rx and kills the valid bit.
    ir1_halt = 1'b1; in_valid = 1'b1; rx_in = rx_rev(); drsel = 2'd0;
    cyc();
    check("ir1_halt_rx", NW'(rx), '0);
    ir1_halt = 1'b0; in_valid = 1'b0;
    cyc();
    check("ir1_halt_valid", NW'(out_valid), '0);

`ifdef CR_PREFIX_DI_PARITY_EN
    coeff_in = '0; coeff_in[7:0] = 8'h07;
    rx_in = '0; rx_in[IDX_W-1:0] = IDX_W'(3); rx_in[2*IDX_W-1:IDX_W] = IDX_W'(1);
    cyc();
    check("coeff_par", NW'(coeff_par), NW'(1));
    cyc();
    check("neuron_par", NW'(neuron_par), NW'(2));
`endif

    // Mid-operation asynchronous reset.
    drsel = 2'd0; rx_in = rx_rev(); in_valid = 1'b1; coeff_in = fill(8'h21);
    cyc();
    cyc();
    #2 rst_n = 1'b0;
    #1;
    check("async_datareg", datareg, '0);
    check("async_rx", NW'(rx), '0);
    check("async_coeff", coeff, '0);
    check("async_neuron", neuron, '0);
    check("async_valid", NW'(out_valid), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
